// File: rtl/pipe_stage_reg.sv
// Pipeline register with valid/ready handshake, two-entry skid buffer and bubble-inserting flush.
// Optional stall counter output enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] NOP_VAL   = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Dout
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  // state | meaning
  // EMPTY | no entry held, Dout shows last bubble/reset value
  // ONE   | main register holds the head entry
  // TWO   | main holds head, skid holds the following entry
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             pop;

  // Handshake outputs come from the state register only, so no ready path runs combinationally.
  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_TWO);
  assign Dout      = main_q;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_EMPTY;
      main_q <= RESET_VAL;
      skid_q <= '0;
    end else if (Flush) begin
      state  <= ST_EMPTY;
      main_q <= NOP_VAL;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_q <= Data;
            state  <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_q <= Data;
          end else if (accept) begin
            skid_q <= Data;
            state  <= ST_TWO;
          end else if (pop) begin
            main_q <= NOP_VAL;
            state  <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_q <= skid_q;
            state  <= ST_ONE;
          end
        end
        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Counts backpressured cycles; survives Flush so stall statistics span branch flushes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline register for the MIPS datapath, the successor to the plain 32-bit write-enabled register. Adds a valid/ready handshake, a two-entry skid buffer and a synchronous flush that inserts a NOP bubble. Used between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) so stalls and branch flushes are handled locally without combinational ready paths.

Parameters:
WIDTH, 32, bit width of the Data and Dout payload
RESET_VAL, 0, value loaded into Dout by RST
NOP_VAL, 0, value loaded into Dout by Flush or when the stage drains empty (MIPS NOP = 32'h00000000)

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  synchronous, active-high reset
Flush  input  1  synchronous flush; discards both entries and inserts a bubble
in_valid  input  1  upstream presents Data
in_ready  output  1  stage can accept; driven from a register only, never from out_ready
Data  input  WIDTH  upstream payload
out_valid  output  1  Dout holds a valid entry
out_ready  input  1  downstream consumes Dout this cycle
Dout  output  WIDTH  main register contents

Behaviour:
- Single clock CLK. RST is synchronous and active-high.
- Storage: main register (drives Dout) and skid register. State is one of EMPTY, ONE or TWO.
- Outputs decode from state: out_valid = (state != EMPTY); in_ready = (state != TWO).
- Transfers: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Priority: RST, then Flush, then normal operation.
- RST: state<=EMPTY, Dout<=RESET_VAL, skid<=0. After RST, out_valid=0 and in_ready=1.
- Flush (RST low): state<=EMPTY, Dout<=NOP_VAL. Any accept or pop in the same cycle is discarded.
- EMPTY:
  - accept -> main<=Data, ONE.
  - else -> stay EMPTY, Dout unchanged.
- ONE:
  - accept & pop -> main<=Data, stay ONE (full throughput).
  - accept & !pop -> skid<=Data, go TWO.
  - !accept & pop -> main<=NOP_VAL, go EMPTY.
  - neither -> hold.
- TWO: in_ready=0, so no accept is possible.
  - pop -> main<=skid, go ONE.
  - else -> hold both entries.
- Latency: Data accepted at edge k appears on Dout with out_valid=1 immediately after edge k.
- Throughput: one entry per cycle while out_ready stays high.
- Ordering: strict FIFO. The skid entry always follows the main entry. No entry is ever dropped or duplicated, except by Flush or RST.
- Dout is stable while out_valid=1 and out_ready=0.
- in_valid=0 cycles ignore Data (X-tolerant).

Optional Feature:
Macro PIPE_STAGE_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt (16 bits).
  - Increments on every cycle with out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by RST only; Flush does not affect it.
  - Counting is registered: the count reflects cycles up to and including the previous edge.
- Not defined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- RST=1 for one edge with RESET_VAL=32'hDEADBEEF -> Dout=32'hDEADBEEF, out_valid=0, in_ready=1.
- out_ready held 1; stream in_valid=1 with Data=1,2,3 on consecutive edges -> Dout=1,2,3 on consecutive cycles, out_valid=1, in_ready never drops.
- out_ready=0; push Data=32'h3 then 32'h5 -> after the 2nd edge in_ready=0, Dout=3. Raise out_ready -> Dout=5 next cycle, then Dout=NOP_VAL with out_valid=0.
- State TWO holding 7,9; assert Flush together with out_ready=1 and in_valid=1 (Data=11) -> next cycle out_valid=0, Dout=NOP_VAL, in_ready=1, and 11 never appears on Dout.
- Store 4 in ONE, assert RST mid-stall -> Dout=RESET_VAL, out_valid=0; stall_cnt=0 when the macro is defined.
- With PIPE_STAGE_STALL_CNT_EN defined: out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt=5; a Flush afterwards leaves stall_cnt=5.
